// File: rtl/saxis_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : saxis_chk_pkg
// Purpose  : Shared definitions for the AXI-Stream frame checker: FSM state
//            encoding, err_flags bit positions and the back-pressure LFSR
//            seed, taps and next-state helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package saxis_chk_pkg;

  // Checker FSM: hunting for start-of-frame, or tracking a locked frame.
  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } chk_state_e;

  // Bit positions inside err_flags.
  localparam int ERR_DATA         = 0;
  localparam int ERR_EARLY_LAST   = 1;
  localparam int ERR_MISSING_LAST = 2;
  localparam int ERR_SOF          = 3;

  // 16-bit Fibonacci LFSR, polynomial taps 16,14,13,11. With a right-shifting
  // register those taps land on state bits 0,2,3,5; their XOR is fed back
  // into bit 15.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/chk_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : chk_lfsr16
// Purpose  : Free-running 16-bit Fibonacci LFSR used to create pseudo-random
//            back-pressure on the checker's TREADY.
// Ports    : clk   - clock (rising edge)
//            rst   - synchronous active-high reset, loads LFSR_SEED
//            state - current LFSR contents
// Revision : 1.0 - initial release
// ============================================================================
module chk_lfsr16
  import saxis_chk_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_SEED;
    end else begin
      state <= lfsr_next(state);
    end
  end

endmodule
`default_nettype wire

// File: rtl/saxis_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : saxis_frame_checker
// Purpose  : AXI-Stream video sink that checks a counting test pattern.
//            Each accepted beat must equal {frame[3:0], line[11:0], word[15:0]},
//            USER must mark line 0 word 0 and TLAST must mark the last word of
//            every line. Errors are latched in sticky err_flags and counted.
// Build option:
//            SAXIS_CHECKER_BACKPRESSURE_EN - when defined, TREADY is throttled
//            by a 16-bit LFSR; otherwise TREADY is held high out of reset.
// Ports    : S_AXIS_ACLK   - sole clock
//            S_AXIS_ARESET - synchronous active-high reset
//            S_AXIS_TVALID / TDATA / TSTRB (ignored) / TLAST (end of line) /
//            USER (start of frame) - stream input
//            S_AXIS_TREADY - sink ready
//            frame_done    - one-cycle pulse at the end of every frame
//            frame_count   - completed frames (wraps)
//            err_count     - error beats (saturating)
//            err_flags     - sticky {SOF, MISSING_LAST, EARLY_LAST, DATA}
//            locked        - a start of frame has been seen
// Revision : 1.0 - initial release
// ============================================================================
module saxis_frame_checker
  import saxis_chk_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int PIXELS_HORIZONTAL    = 1280,
  parameter int PIXELS_VERTICAL      = 1024
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESET,
  input  logic                              S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_USER,
  output logic                              S_AXIS_TREADY,
  output logic                              frame_done,
  output logic [15:0]                       frame_count,
  output logic [15:0]                       err_count,
  output logic [3:0]                        err_flags,
  output logic                              locked
);

  localparam int          WPL       = PIXELS_HORIZONTAL / 4;
  localparam logic [15:0] LAST_WORD = 16'(WPL - 1);
  localparam logic [11:0] LAST_LINE = 12'(PIXELS_VERTICAL - 1);

  // --------------------------------------------------------------------------
  // Input normalisation: the pattern is defined on 32 bits.
  // --------------------------------------------------------------------------
  logic [31:0] data32;
  logic        unused_strb;

  assign unused_strb = ^S_AXIS_TSTRB;

  generate
    if (C_S_AXIS_TDATA_WIDTH >= 32) begin : g_wide
      assign data32 = S_AXIS_TDATA[31:0];
      if (C_S_AXIS_TDATA_WIDTH > 32) begin : g_upper
        logic unused_upper;
        assign unused_upper = ^S_AXIS_TDATA[C_S_AXIS_TDATA_WIDTH-1:32];
      end
    end else begin : g_narrow
      assign data32 = 32'(S_AXIS_TDATA);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Ready generation. 'run' keeps TREADY low until the first clock after
  // reset has been released.
  // --------------------------------------------------------------------------
  logic run;
  logic ready_gate;

`ifdef SAXIS_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr_state;
  logic        unused_lfsr_hi;

  chk_lfsr16 u_lfsr (
    .clk   (S_AXIS_ACLK),
    .rst   (S_AXIS_ARESET),
    .state (lfsr_state)
  );

  assign ready_gate     = (lfsr_state[1:0] != 2'b00);
  assign unused_lfsr_hi = ^lfsr_state[15:2];
`else
  assign ready_gate = 1'b1;
`endif

  assign S_AXIS_TREADY = run & ready_gate;

  logic accepted;
  assign accepted = S_AXIS_TVALID & S_AXIS_TREADY;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  chk_state_e  state, state_next;
  logic [3:0]  exp_frame, exp_frame_next;
  logic [11:0] exp_line, exp_line_next;
  logic [15:0] exp_word, exp_word_next;
  logic [15:0] frame_count_next;
  logic [15:0] err_count_next;
  logic [3:0]  err_flags_next;
  logic        locked_next;
  logic        frame_done_next;

  // Per-beat evaluation scratch
  logic        eval;
  logic        at_sof;
  logic [3:0]  chk_frame;
  logic [11:0] chk_line;
  logic [15:0] chk_word;
  logic [31:0] expected;
  logic [3:0]  beat_err;

  always_comb begin
    state_next       = state;
    exp_frame_next   = exp_frame;
    exp_line_next    = exp_line;
    exp_word_next    = exp_word;
    frame_count_next = frame_count;
    err_count_next   = err_count;
    err_flags_next   = err_flags;
    locked_next      = locked;
    frame_done_next  = 1'b0;
    eval             = 1'b0;
    at_sof           = (exp_line == 12'd0) && (exp_word == 16'd0);
    chk_frame        = exp_frame;
    chk_line         = exp_line;
    chk_word         = exp_word;
    expected         = 32'd0;
    beat_err         = 4'b0000;

    if (accepted) begin
      case (state)
        WAIT_SOF: begin
          // Anything before the first SOF is discarded without checking.
          if (S_AXIS_USER) begin
            eval        = 1'b1;
            chk_frame   = data32[31:28];
            chk_line    = 12'd0;
            chk_word    = 16'd0;
            locked_next = 1'b1;
            state_next  = IN_FRAME;
          end
        end
        IN_FRAME: begin
          eval = 1'b1;
          if (S_AXIS_USER && !at_sof) begin
            // Unexpected SOF: believe the source and restart the frame here.
            beat_err[ERR_SOF] = 1'b1;
            chk_frame         = data32[31:28];
            chk_line          = 12'd0;
            chk_word          = 16'd0;
          end else if (!S_AXIS_USER && at_sof) begin
            beat_err[ERR_SOF] = 1'b1;
          end
        end
        default: begin
          state_next = WAIT_SOF;
        end
      endcase

      if (eval) begin
        expected = {chk_frame, chk_line, chk_word};
        if (data32 != expected) begin
          beat_err[ERR_DATA] = 1'b1;
        end
        if (S_AXIS_TLAST && (chk_word < LAST_WORD)) begin
          beat_err[ERR_EARLY_LAST] = 1'b1;
        end
        if (!S_AXIS_TLAST && (chk_word == LAST_WORD)) begin
          beat_err[ERR_MISSING_LAST] = 1'b1;
        end

        // Either a TLAST or the nominal last word closes the line.
        exp_frame_next = chk_frame;
        if (S_AXIS_TLAST || (chk_word == LAST_WORD)) begin
          exp_word_next = 16'd0;
          if (chk_line == LAST_LINE) begin
            exp_line_next    = 12'd0;
            exp_frame_next   = chk_frame + 4'd1;
            frame_count_next = frame_count + 16'd1;
            frame_done_next  = 1'b1;
          end else begin
            exp_line_next = chk_line + 12'd1;
          end
        end else begin
          exp_line_next = chk_line;
          exp_word_next = chk_word + 16'd1;
        end

        err_flags_next = err_flags | beat_err;
        if ((beat_err != 4'b0000) && (err_count != 16'hFFFF)) begin
          err_count_next = err_count + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state       <= WAIT_SOF;
      run         <= 1'b0;
      exp_frame   <= 4'd0;
      exp_line    <= 12'd0;
      exp_word    <= 16'd0;
      frame_count <= 16'd0;
      err_count   <= 16'd0;
      err_flags   <= 4'd0;
      locked      <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_next;
      run         <= 1'b1;
      exp_frame   <= exp_frame_next;
      exp_line    <= exp_line_next;
      exp_word    <= exp_word_next;
      frame_count <= frame_count_next;
      err_count   <= err_count_next;
      err_flags   <= err_flags_next;
      locked      <= locked_next;
      frame_done  <= frame_done_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_saxis_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_saxis_frame_checker
// Purpose  : Self-checking bench for saxis_frame_checker with a 16x3 frame
//            (4 words per line, 3 lines). A beat-level reference model tracks
//            the expected position, flags and counters from accepted beats.
//            Honours SAXIS_CHECKER_BACKPRESSURE_EN for the stall scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_saxis_frame_checker;

  localparam int PH  = 16;
  localparam int PV  = 3;
  localparam int WPL = PH / 4;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        tvalid = 1'b0;
  logic [31:0] tdata  = 32'd0;
  logic [3:0]  tstrb  = 4'hF;
  logic        tlast  = 1'b0;
  logic        user   = 1'b0;
  logic        tready;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [15:0] err_count;
  logic [3:0]  err_flags;
  logic        locked;

  saxis_frame_checker #(
    .C_S_AXIS_TDATA_WIDTH (32),
    .PIXELS_HORIZONTAL    (PH),
    .PIXELS_VERTICAL      (PV)
  ) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESET (rst),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TSTRB  (tstrb),
    .S_AXIS_TLAST  (tlast),
    .S_AXIS_USER   (user),
    .S_AXIS_TREADY (tready),
    .frame_done    (frame_done),
    .frame_count   (frame_count),
    .err_count     (err_count),
    .err_flags     (err_flags),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit         m_sync;
  bit         m_locked;
  int         m_f, m_l, m_w;
  int         m_fc, m_errc, m_done;
  logic [3:0] m_flags;

  // Monitors
  int   done_seen    = 0;
  int   double_pulse = 0;
  int   stall_cycles = 0;
  logic prev_done    = 1'b0;

  always @(negedge clk) begin
    if (frame_done) done_seen <= done_seen + 1;
    if (frame_done && prev_done) double_pulse <= double_pulse + 1;
    prev_done <= frame_done;
    if (tvalid && !tready && !rst) stall_cycles <= stall_cycles + 1;
  end

  function automatic logic [31:0] pix(input int f, input int l, input int w);
    logic [3:0]  ff;
    logic [11:0] ll;
    logic [15:0] ww;
    ff = f[3:0];
    ll = l[11:0];
    ww = w[15:0];
    return {ff, ll, ww};
  endfunction

  task automatic model_reset();
    m_sync = 0; m_locked = 0;
    m_f = 0; m_l = 0; m_w = 0;
    m_fc = 0; m_errc = 0; m_done = 0;
    m_flags = 4'b0000;
  endtask

  // One accepted beat, following the pattern rules directly.
  task automatic model_beat(input logic [31:0] d, input logic u, input logic l);
    logic [3:0] e;
    e = 4'b0000;
    if (!m_sync) begin
      if (!u) return;
      m_sync = 1; m_locked = 1;
      m_f = int'(d[31:28]); m_l = 0; m_w = 0;
    end else if (u && !(m_l == 0 && m_w == 0)) begin
      e[3] = 1'b1;
      m_f = int'(d[31:28]); m_l = 0; m_w = 0;
    end else if (!u && m_l == 0 && m_w == 0) begin
      e[3] = 1'b1;
    end
    if (d !== pix(m_f, m_l, m_w)) e[0] = 1'b1;
    if (l && m_w < WPL - 1) e[1] = 1'b1;
    if (!l && m_w == WPL - 1) e[2] = 1'b1;
    if (l || m_w == WPL - 1) begin
      m_w = 0;
      m_l = m_l + 1;
      if (m_l == PV) begin
        m_l = 0;
        m_f = (m_f + 1) % 16;
        m_fc = (m_fc + 1) % 65536;
        m_done = m_done + 1;
      end
    end else begin
      m_w = m_w + 1;
    end
    m_flags = m_flags | e;
    if (e != 4'b0000 && m_errc < 65535) m_errc = m_errc + 1;
  endtask

  // Present a beat at the falling edge and hold it until accepted.
  task automatic send_beat(input logic [31:0] d, input logic u, input logic l);
    bit acc;
    acc = 0;
    @(negedge clk);
    tvalid = 1'b1; tdata = d; user = u; tlast = l;
    for (int k = 0; k < 64; k++) begin
      acc = tready;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL beat_accept timeout data=%h tready=%b required=1", d, tready);
    end else begin
      model_beat(d, u, l);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tvalid = 1'b0; user = 1'b0; tlast = 1'b0;
    end
  endtask

  task automatic send_frame(input int f, input int gap_max);
    for (int l = 0; l < PV; l++) begin
      for (int w = 0; w < WPL; w++) begin
        send_beat(pix(f, l, w), (l == 0 && w == 0), (w == WPL - 1));
        idle(int'($urandom_range(gap_max, 0)));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tvalid = 1'b0; user = 1'b0; tlast = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; tvalid = 1'b1; tdata = 32'h0; user = 1'b1; tlast = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({tready, frame_done, locked} !== 3'b000) begin
      bad++; $display("FAIL reset_bits got tready/done/locked=%b required=000", {tready, frame_done, locked});
    end
    total++;
    if ({frame_count, err_count, err_flags} !== 36'd0) begin
      bad++; $display("FAIL reset_counters got fc=%0d ec=%0d flags=%b required 0", frame_count, err_count, err_flags);
    end
    rst = 1'b0; tvalid = 1'b0; user = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
`ifndef SAXIS_CHECKER_BACKPRESSURE_EN
    total++;
    if (tready !== 1'b1) begin
      bad++; $display("FAIL ready_after_reset got=%b required=1", tready);
    end
`endif
    total++;
    if (locked !== 1'b0) begin
      bad++; $display("FAIL idle_unlocked got=%b required=0", locked);
    end
  endtask

  task automatic test_clean();
    int base;
    do_reset();
    base = done_seen;
    send_frame(0, 2);
    send_frame(1, 2);
    idle(4);
    total++;
    if (done_seen - base !== 2) begin
      bad++; $display("FAIL clean_done_pulses got=%0d required=2", done_seen - base);
    end
    total++;
    if (frame_count !== 16'd2) begin
      bad++; $display("FAIL clean_frame_count got=%0d required=2", frame_count);
    end
    total++;
    if (err_flags !== 4'b0000 || err_count !== 16'd0) begin
      bad++; $display("FAIL clean_errors got flags=%b ec=%0d required 0000/0", err_flags, err_count);
    end
    total++;
    if (double_pulse !== 0) begin
      bad++; $display("FAIL done_width got double=%0d required=0", double_pulse);
    end
  endtask

  task automatic test_junk();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      send_beat($urandom | 32'h1, 1'b0, 1'($urandom_range(1, 0)));
    end
    idle(3);
    total++;
    if (locked !== 1'b0 || err_count !== 16'd0) begin
      bad++; $display("FAIL junk_prelock got locked=%b ec=%0d required 0/0", locked, err_count);
    end
    send_beat(pix(0, 0, 0), 1'b1, 1'b0);
    idle(2);
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL junk_lock got=%b required=1", locked);
    end
    for (int i = 1; i < PV * WPL; i++) send_beat(pix(0, i / WPL, i % WPL), 1'b0, (i % WPL) == WPL - 1);
    idle(3);
    total++;
    if (err_count !== 16'd0 || frame_count !== 16'd1) begin
      bad++; $display("FAIL junk_frame got ec=%0d fc=%0d required 0/1", err_count, frame_count);
    end
  endtask

  task automatic test_corrupt();
    int base;
    do_reset();
    base = done_seen;
    for (int i = 0; i < PV * WPL; i++) begin
      send_beat((i == WPL + 2) ? 32'h0001_0007 : pix(0, i / WPL, i % WPL),
                i == 0, (i % WPL) == WPL - 1);
    end
    idle(3);
    total++;
    if (err_flags !== 4'b0001 || err_count !== 16'd1) begin
      bad++; $display("FAIL corrupt_flags got flags=%b ec=%0d required 0001/1", err_flags, err_count);
    end
    total++;
    if (done_seen - base !== 1) begin
      bad++; $display("FAIL corrupt_done got=%0d required=1", done_seen - base);
    end
  endtask

  task automatic test_early_last();
    do_reset();
    send_beat(pix(0, 0, 0), 1'b1, 1'b0);
    send_beat(pix(0, 0, 1), 1'b0, 1'b1);
    idle(2);
    total++;
    if (err_flags !== 4'b0010 || err_count !== 16'd1) begin
      bad++; $display("FAIL early_last got flags=%b ec=%0d required 0010/1", err_flags, err_count);
    end
    for (int i = WPL; i < PV * WPL; i++) send_beat(pix(0, i / WPL, i % WPL), 1'b0, (i % WPL) == WPL - 1);
    idle(3);
    total++;
    if (err_count !== 16'd1 || frame_count !== 16'd1) begin
      bad++; $display("FAIL early_last_recover got ec=%0d fc=%0d required 1/1", err_count, frame_count);
    end
  endtask

  task automatic test_resync();
    int base;
    do_reset();
    base = done_seen;
    for (int w = 0; w < WPL; w++) send_beat(pix(0, 0, w), w == 0, w == WPL - 1);
    send_beat(32'h5000_0000, 1'b1, 1'b0);
    idle(2);
    total++;
    if (err_flags !== 4'b1000 || err_count !== 16'd1) begin
      bad++; $display("FAIL resync_flag got flags=%b ec=%0d required 1000/1", err_flags, err_count);
    end
    for (int i = 1; i < PV * WPL; i++) send_beat(pix(5, i / WPL, i % WPL), 1'b0, (i % WPL) == WPL - 1);
    send_frame(6, 1);
    idle(3);
    total++;
    if (err_count !== 16'd1 || frame_count !== 16'd2 || done_seen - base !== 2) begin
      bad++; $display("FAIL resync_follow got ec=%0d fc=%0d done=%0d required 1/2/2",
                      err_count, frame_count, done_seen - base);
    end
  endtask

  task automatic test_multi_error();
    do_reset();
    send_beat(pix(3, 0, 0), 1'b1, 1'b0);
    send_beat(32'hDEAD_BEEF, 1'b0, 1'b1);
    idle(2);
    total++;
    if (err_flags !== 4'b0011 || err_count !== 16'd1) begin
      bad++; $display("FAIL multi_error got flags=%b ec=%0d required 0011/1", err_flags, err_count);
    end
  endtask

  task automatic test_random();
    int base;
    do_reset();
    base = done_seen;
    for (int k = 0; k < 3; k++) send_beat($urandom, 1'b0, 1'b0);
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < PV * WPL; i++) begin
        logic [31:0] d;
        logic        u, l;
        int          r;
        d = pix(f + 2, i / WPL, i % WPL);
        u = (i == 0);
        l = ((i % WPL) == WPL - 1);
        r = int'($urandom_range(99, 0));
        if (r < 6) d = d ^ (32'h1 << $urandom_range(31, 0));
        else if (r < 9) l = ~l;
        else if (r < 11) u = ~u;
        send_beat(d, u, l);
        idle(int'($urandom_range(1, 0)));
      end
    end
    idle(3);
    total++;
    if (frame_count !== m_fc[15:0] || done_seen - base !== m_done) begin
      bad++; $display("FAIL random_frames got fc=%0d done=%0d required %0d/%0d",
                      frame_count, done_seen - base, m_fc, m_done);
    end
    total++;
    if (err_count !== m_errc[15:0] || err_flags !== m_flags) begin
      bad++; $display("FAIL random_errors got ec=%0d flags=%b required %0d/%b",
                      err_count, err_flags, m_errc, m_flags);
    end
    total++;
    if (locked !== m_locked) begin
      bad++; $display("FAIL random_locked got=%b required=%b", locked, m_locked);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_frame(0, 0);
    for (int i = 0; i < 6; i++) send_beat(pix(1, i / WPL, i % WPL), i == 0, (i % WPL) == WPL - 1);
    @(negedge clk);
    rst = 1'b1; tvalid = 1'b1; tdata = pix(1, 1, 2); user = 1'b0; tlast = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({frame_count, err_count, err_flags, locked, frame_done, tready} !== 39'd0) begin
      bad++; $display("FAIL midframe_reset got fc=%0d ec=%0d flags=%b lk=%b fd=%b rdy=%b required all 0",
                      frame_count, err_count, err_flags, locked, frame_done, tready);
    end
    rst = 1'b0; tvalid = 1'b0;
    model_reset();
    send_beat(pix(1, 1, 3), 1'b0, 1'b1);
    send_beat(pix(1, 2, 0), 1'b0, 1'b0);
    send_frame(2, 1);
    idle(3);
    total++;
    if (locked !== 1'b1 || frame_count !== 16'd1 || err_count !== 16'd0) begin
      bad++; $display("FAIL midframe_relock got lk=%b fc=%0d ec=%0d required 1/1/0",
                      locked, frame_count, err_count);
    end
  endtask

`ifdef SAXIS_CHECKER_BACKPRESSURE_EN
  task automatic test_backpressure();
    int sbase;
    do_reset();
    sbase = stall_cycles;
    send_frame(0, 0);
    send_frame(1, 0);
    send_frame(2, 0);
    idle(3);
    total++;
    if (frame_count !== 16'd3 || err_flags !== 4'b0000) begin
      bad++; $display("FAIL bp_frames got fc=%0d flags=%b required 3/0000", frame_count, err_flags);
    end
    total++;
    if (stall_cycles - sbase <= 0) begin
      bad++; $display("FAIL bp_stalls got=%0d required>0", stall_cycles - sbase);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_clean();
    test_junk();
    test_corrupt();
    test_early_last();
    test_resync();
    test_multi_error();
    test_random();
    test_reset_midframe();
`ifdef SAXIS_CHECKER_BACKPRESSURE_EN
    test_backpressure();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a scenario wedges.
  initial begin
    #500000;
    $display("FAIL global_timeout reached required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
